pe_output_collector: RTL

Downstream drain stage for the PE matrix. It snapshots the per-array 32-bit `accumulated_output` lanes on a capture strobe from the accelerator controller. Each lane is requantised to a signed 8-bit activation (optional ReLU, rounding right shift, saturation), and the results are buffered in a small FIFO. Results leave on a single valid/ready stream, lane 0 first, so the matrix can be reset and reused while earlier results drain.

---
 rtl/pe_output_collector_if.sv | 29 ++
 rtl/pe_output_collector.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_output_collector_if.sv
// Interface bundling the capture command, lane data, result stream and status
// of the PE output collector. The controller side is master; the collector is slave.
interface pe_output_collector_if #(
  parameter int NUM_ARRAYS = 4,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 8
) ();
  logic                        capture;
  logic [NUM_ARRAYS*ACC_W-1:0] accumulated_output;
  logic [4:0]                  shift;
  logic                        relu_en;
  logic                        clr_overflow;
  logic [OUT_W-1:0]            out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        busy;
  logic                        done;
  logic                        overflow;

  modport master (
    output capture, accumulated_output, shift, relu_en, clr_overflow, out_ready,
    input  out_data, out_valid, busy, done, overflow
  );

  modport slave (
    input  capture, accumulated_output, shift, relu_en, clr_overflow, out_ready,
    output out_data, out_valid, busy, done, overflow
  );
endinterface

// File: rtl/pe_output_collector.sv
// PE output collector: snapshots all accumulator lanes on a capture strobe,
// requantises one lane per cycle (ReLU, rounding shift, saturation) into a
// result FIFO and drains it over a valid/ready stream, lane 0 first.
module pe_output_collector #(
  parameter int NUM_ARRAYS = 4,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  pe_output_collector_if.slave    bus
);

  localparam int LANE_W = (NUM_ARRAYS > 1) ? $clog2(NUM_ARRAYS) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_ARRAYS - 1);
  localparam int                MAX_I     = 2 ** (OUT_W - 1) - 1;
  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'(MAX_I);
  localparam logic signed [ACC_W:0] MIN_V = (ACC_W+1)'(-MAX_I - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [LANE_W-1:0]   r_lane;
  logic [ACC_W-1:0]    r_snap [NUM_ARRAYS];
  logic [ACC_W-1:0]    w_lanes [NUM_ARRAYS];
  logic [4:0]          r_shift;
  logic                r_relu;
  logic                r_done;
  logic                r_overflow;

  logic [OUT_W-1:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_pop;
  logic                w_push;
  logic                w_accept;
  logic                w_drop;
  logic                w_last;
  logic                w_space_ok;
  logic [CNT_W-1:0]    w_free;
  logic [ACC_W-1:0]    w_lane_val;
  logic [OUT_W-1:0]    w_result;

  // Requantise one lane: optional ReLU, round-half-up arithmetic shift, saturate.
  // Done at ACC_W+1 bits so the rounding bias can never wrap.
  function automatic logic [OUT_W-1:0] requant(
    input logic [ACC_W-1:0] lane,
    input logic [4:0]       sh,
    input logic             relu
  );
    logic signed [ACC_W:0] v;
    logic signed [ACC_W:0] bias;
    logic [OUT_W-1:0]      res;
    v    = {lane[ACC_W-1], lane};
    bias = '0;
    if (relu && (v < 0)) begin
      v = '0;
    end
    if (sh != 5'd0) begin
      bias = (ACC_W+1)'(1) << (sh - 5'd1);
      v    = (v + bias) >>> sh;
    end
    if (v > MAX_V) begin
      res = MAX_V[OUT_W-1:0];
    end else if (v < MIN_V) begin
      res = MIN_V[OUT_W-1:0];
    end else begin
      res = v[OUT_W-1:0];
    end
    return res;
  endfunction

  // Unpack the flattened lane bus into an array of lanes.
  for (genvar gi = 0; gi < NUM_ARRAYS; gi++) begin : g_lane
    assign w_lanes[gi] = bus.accumulated_output[gi*ACC_W +: ACC_W];
  end

  // Free space counts a same-cycle pop so a draining FIFO can accept sooner.
  assign w_pop      = bus.out_valid && bus.out_ready;
  assign w_free     = CNT_W'(FIFO_DEPTH) - r_count + CNT_W'(w_pop);
  assign w_space_ok = (w_free >= CNT_W'(NUM_ARRAYS));
  assign w_drop     = bus.capture && !w_accept;

  assign w_lane_val = r_snap[r_lane];
  assign w_result   = requant(w_lane_val, r_shift, r_relu);

  // Next-state logic: accept captures in IDLE with room reserved, scan lanes in SCAN.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_push       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.capture && w_space_ok) begin
          w_accept     = 1'b1;
          w_state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_push = 1'b1;
        if (r_lane == LAST_LANE) begin
          w_last       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Snapshot lanes and requant settings on acceptance; advance lane index while scanning.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ARRAYS; i++) begin
        r_snap[i] <= '0;
      end
      r_shift <= '0;
      r_relu  <= 1'b0;
      r_lane  <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_ARRAYS; i++) begin
        r_snap[i] <= w_lanes[i];
      end
      r_shift <= bus.shift;
      r_relu  <= bus.relu_en;
      r_lane  <= '0;
    end else if (w_push) begin
      r_lane <= r_lane + LANE_W'(1);
    end
  end

  // Done pulse follows the last push; overflow is sticky with set winning over clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_result;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = bus.out_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.busy      = (r_state == ST_SCAN);
  assign bus.done      = r_done;
  assign bus.overflow  = r_overflow;

endmodule
